// File: rtl/clock_pkg.sv
// Shared encodings for the digital clock: mode codes, field/button indices and time limits.
package clock_pkg;

    typedef enum logic [2:0] {
        MODE_RUN     = 3'd0,
        MODE_SET_HR  = 3'd1,
        MODE_SET_MIN = 3'd2,
        MODE_SET_SEC = 3'd3,
        MODE_SET_MON = 3'd4,
        MODE_SET_DAY = 3'd5
    } mode_e;

    localparam int unsigned NUM_FLD = 5;
    localparam int unsigned NUM_BTN = 4;

    localparam int unsigned FLD_HR  = 0;
    localparam int unsigned FLD_MIN = 1;
    localparam int unsigned FLD_SEC = 2;
    localparam int unsigned FLD_MON = 3;
    localparam int unsigned FLD_DAY = 4;

    localparam int unsigned BTN_INC  = 0;
    localparam int unsigned BTN_NEXT = 1;
    localparam int unsigned BTN_DEC  = 2;
    localparam int unsigned BTN_EXIT = 3;

    localparam int unsigned HR_MAX  = 23;
    localparam int unsigned MIN_MAX = 59;
    localparam int unsigned SEC_MAX = 59;

    // One-hot field select for the field edited in a given SET mode; zero in RUN.
    function automatic logic [NUM_FLD-1:0] fld_onehot(input mode_e m);
        fld_onehot = '0;
        case (m)
            MODE_SET_HR:  fld_onehot[FLD_HR]  = 1'b1;
            MODE_SET_MIN: fld_onehot[FLD_MIN] = 1'b1;
            MODE_SET_SEC: fld_onehot[FLD_SEC] = 1'b1;
            MODE_SET_MON: fld_onehot[FLD_MON] = 1'b1;
            MODE_SET_DAY: fld_onehot[FLD_DAY] = 1'b1;
            default:      fld_onehot = '0;
        endcase
    endfunction

endpackage

// File: rtl/btn_pulse.sv
// Registered rising-edge detector: one-cycle pulse the cycle after a level first samples high.
module btn_pulse (
    input  logic clk,
    input  logic rst,
    input  logic lvl_i,
    output logic pulse_o
);

    logic lvl_q;
    logic pulse_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            lvl_q   <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            lvl_q   <= lvl_i;
            pulse_q <= lvl_i & ~lvl_q;
        end
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/clock_set_ctrl.sv
// RUN/SET mode controller: decodes buttons into field strobes, gates counting,
// times out idle edits and issues the midnight day-advance strobe.
module clock_set_ctrl
    import clock_pkg::*;
#(
    parameter int unsigned TIMEOUT_S = 30,
    parameter int unsigned TO_W      = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_BTN-1:0]   btn,
    input  logic                 tick_1hz,
    input  logic [5:0]           hr,
    input  logic [5:0]           min,
    input  logic [5:0]           sec,
    output logic [2:0]           mode,
    output logic                 run_en,
    output logic [NUM_FLD-1:0]   inc_fld,
    output logic [NUM_FLD-1:0]   dec_fld,
    output logic                 date_inc,
    output logic                 blink
);

    logic [NUM_BTN-1:0] p;

    for (genvar i = 0; i < int'(NUM_BTN); i++) begin : g_pulse
        btn_pulse u_pulse (
            .clk     (clk),
            .rst     (rst),
            .lvl_i   (btn[i]),
            .pulse_o (p[i])
        );
    end

    // Fixed priority EXIT > NEXT > INC > DEC; lower pulses are dropped.
    logic p_exit, p_next, p_inc, p_dec;
    assign p_exit = p[BTN_EXIT];
    assign p_next = p[BTN_NEXT] & ~p[BTN_EXIT];
    assign p_inc  = p[BTN_INC]  & ~p[BTN_EXIT] & ~p[BTN_NEXT];
    assign p_dec  = p[BTN_DEC]  & ~p[BTN_EXIT] & ~p[BTN_NEXT] & ~p[BTN_INC];

    mode_e              mode_q, mode_d;
    logic [NUM_FLD-1:0] inc_q, inc_d;
    logic [NUM_FLD-1:0] dec_q, dec_d;
    logic               date_q, date_d;
    logic               blink_q, blink_d;
    logic [TO_W-1:0]    to_q, to_d;

    logic in_set;
    logic timed_out;
    logic midnight;

    assign in_set    = mode_q inside {MODE_SET_HR, MODE_SET_MIN, MODE_SET_SEC,
                                      MODE_SET_MON, MODE_SET_DAY};
    assign timed_out = in_set && (to_q == TO_W'(TIMEOUT_S));
    assign midnight  = (hr == 6'(HR_MAX)) && (min == 6'(MIN_MAX)) && (sec == 6'(SEC_MAX));

    always_comb begin
        mode_d  = mode_q;
        inc_d   = '0;
        dec_d   = '0;
        date_d  = 1'b0;
        blink_d = blink_q;
        to_d    = to_q;

        case (mode_q)
            MODE_RUN:     if (p_next) mode_d = MODE_SET_HR;
            MODE_SET_HR:  if (p_next) mode_d = MODE_SET_MIN;
            MODE_SET_MIN: if (p_next) mode_d = MODE_SET_SEC;
            MODE_SET_SEC: if (p_next) mode_d = MODE_SET_MON;
            MODE_SET_MON: if (p_next) mode_d = MODE_SET_DAY;
            MODE_SET_DAY: if (p_next) mode_d = MODE_RUN;
            default:      mode_d = MODE_RUN;
        endcase

        // Timeout overrides any button action in the same cycle.
        if (in_set && (p_exit || timed_out)) begin
            mode_d = MODE_RUN;
        end

        if (in_set && !timed_out) begin
            if (p_inc) inc_d = fld_onehot(mode_q);
            if (p_dec) dec_d = fld_onehot(mode_q);
        end

        date_d = (mode_q == MODE_RUN) && tick_1hz && midnight;

        if ((mode_d != mode_q) || !in_set) begin
            to_d    = '0;
            blink_d = 1'b0;
        end else begin
            if (|p) begin
                to_d = '0;
            end else if (tick_1hz && (to_q != TO_W'(TIMEOUT_S))) begin
                to_d = to_q + TO_W'(1);
            end
            if (tick_1hz) blink_d = ~blink_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q  <= MODE_RUN;
            inc_q   <= '0;
            dec_q   <= '0;
            date_q  <= 1'b0;
            blink_q <= 1'b0;
            to_q    <= '0;
        end else begin
            mode_q  <= mode_d;
            inc_q   <= inc_d;
            dec_q   <= dec_d;
            date_q  <= date_d;
            blink_q <= blink_d;
            to_q    <= to_d;
        end
    end

    assign mode     = mode_q;
    assign run_en   = (mode_q == MODE_RUN);
    assign inc_fld  = inc_q;
    assign dec_fld  = dec_q;
    assign date_inc = date_q;
    assign blink    = blink_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Bench for clock_set_ctrl: vector table, directed corner sequences and random stimulus vs. a behavioural model.
module tb_clock_set_ctrl;

    localparam int TO = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] btn = 4'd0;
    logic       tick_1hz = 1'b0;
    logic [5:0] hr = 6'd0, min = 6'd0, sec = 6'd0;
    logic [2:0] mode;
    logic       run_en;
    logic [4:0] inc_fld, dec_fld;
    logic       date_inc, blink;

    clock_set_ctrl #(.TIMEOUT_S(3), .TO_W(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .btn      (btn),
        .tick_1hz (tick_1hz),
        .hr       (hr),
        .min      (min),
        .sec      (sec),
        .mode     (mode),
        .run_en   (run_en),
        .inc_fld  (inc_fld),
        .dec_fld  (dec_fld),
        .date_inc (date_inc),
        .blink    (blink)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Behavioural model: mode as integer 0..5, pending presses as a bit set.
    int         m_mode = 0;
    int         m_to = 0;
    logic [4:0] m_inc = 5'd0, m_dec = 5'd0;
    logic       m_date = 1'b0, m_blink = 1'b0;
    logic [3:0] m_pend = 4'd0, m_last = 4'd0;

    // Observation counters for the directed sequences.
    int inc_min_cnt = 0, dec_min_cnt = 0, other_fld_cnt = 0, date_cnt = 0, chg_cnt = 0;
    logic [2:0] prev_mode = 3'd0;

    typedef struct {
        logic       r;
        logic [3:0] b;
        logic       t;
        logic       mid;
        logic [2:0] mode;
        logic [4:0] inc;
        logic [4:0] dec;
        logic       date;
        logic       blink;
    } vec_t;

    vec_t tbl [24];

    function automatic vec_t mk(input logic r, input logic [3:0] b, input logic t, input logic mid,
                                input logic [2:0] md, input logic [4:0] inc, input logic [4:0] dec,
                                input logic date, input logic bl);
        vec_t v;
        v.r = r; v.b = b; v.t = t; v.mid = mid;
        v.mode = md; v.inc = inc; v.dec = dec; v.date = date; v.blink = bl;
        return v;
    endfunction

    task automatic model_step(input logic [3:0] b, input logic t, input logic r, input logic mid);
        int act;
        int nxt;
        int old;
        if (r) begin
            m_mode = 0; m_to = 0; m_inc = 5'd0; m_dec = 5'd0;
            m_date = 1'b0; m_blink = 1'b0; m_pend = 4'd0; m_last = 4'd0;
            return;
        end
        old    = m_mode;
        m_date = (old == 0) && t && mid;
        m_inc  = 5'd0;
        m_dec  = 5'd0;
        if (m_pend[3])      act = 3;
        else if (m_pend[1]) act = 1;
        else if (m_pend[0]) act = 0;
        else if (m_pend[2]) act = 2;
        else                act = -1;
        nxt = old;
        if (old == 0) begin
            if (act == 1) nxt = 1;
        end else if (m_to >= TO) begin
            nxt = 0;
        end else if (act == 3) begin
            nxt = 0;
        end else if (act == 1) begin
            nxt = (old + 1) % 6;
        end else if (act == 0) begin
            m_inc = 5'(1 << (old - 1));
        end else if (act == 2) begin
            m_dec = 5'(1 << (old - 1));
        end
        if (nxt != old || old == 0) begin
            m_to = 0;
            m_blink = 1'b0;
        end else begin
            if (m_pend != 4'd0)      m_to = 0;
            else if (t && m_to < TO) m_to = m_to + 1;
            if (t) m_blink = ~m_blink;
        end
        m_mode = nxt;
        m_pend = b & ~m_last;
        m_last = b;
    endtask

    task automatic cmp_out(input string name, input logic [15:0] exp);
        logic [15:0] got;
        got = {mode, run_en, inc_fld, dec_fld, date_inc, blink};
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got mode=%0d run_en=%b inc=%b dec=%b date=%b blink=%b, expected mode=%0d run_en=%b inc=%b dec=%b date=%b blink=%b",
                     name, got[15:13], got[12], got[11:7], got[6:2], got[1], got[0],
                     exp[15:13], exp[12], exp[11:7], exp[6:2], exp[1], exp[0]);
        end
    endtask

    task automatic chk(input string name, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    // One clock: drive inputs, advance the model at the edge, compare at the falling edge.
    task automatic step(input logic [3:0] b, input logic t, input logic r, input logic mid);
        btn = b; tick_1hz = t; rst = r;
        if (mid) begin hr = 6'd23; min = 6'd59; sec = 6'd59; end
        else     begin hr = 6'd12; min = 6'd30; sec = 6'd15; end
        @(posedge clk);
        model_step(b, t, r, mid);
        @(negedge clk);
        cmp_out("model", {3'(m_mode), (m_mode == 0), m_inc, m_dec, m_date, m_blink});
        if (inc_fld == 5'b00010) inc_min_cnt++;
        else if (inc_fld != 5'd0) other_fld_cnt++;
        if (dec_fld == 5'b00010) dec_min_cnt++;
        else if (dec_fld != 5'd0) other_fld_cnt++;
        if (date_inc) date_cnt++;
        if (mode != prev_mode) chg_cnt++;
        prev_mode = mode;
    endtask

    task automatic press(input logic [3:0] b);
        step(b, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 9; k++) step(4'd0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [3:0] rb;
        @(negedge clk);

        // Reset and idle.
        step(4'd0, 1'b0, 1'b1, 1'b0);
        step(4'd0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 100; i++) begin
            step(4'd0, 1'b0, 1'b0, 1'b0);
            cmp_out("idle", 16'h1000);
        end

        //         r  btn    t  mid  mode  inc       dec       date blink
        tbl[0]  = mk(1, 4'h0, 0, 0, 3'd0, 5'b00000, 5'b00000, 0, 0);
        tbl[1]  = mk(0, 4'h0, 0, 0, 3'd0, 5'b00000, 5'b00000, 0, 0);
        tbl[2]  = mk(0, 4'h2, 0, 0, 3'd0, 5'b00000, 5'b00000, 0, 0);
        tbl[3]  = mk(0, 4'h2, 0, 0, 3'd1, 5'b00000, 5'b00000, 0, 0);
        tbl[4]  = mk(0, 4'h0, 0, 0, 3'd1, 5'b00000, 5'b00000, 0, 0);
        tbl[5]  = mk(0, 4'h1, 0, 0, 3'd1, 5'b00000, 5'b00000, 0, 0);
        tbl[6]  = mk(0, 4'h0, 0, 0, 3'd1, 5'b00001, 5'b00000, 0, 0);
        tbl[7]  = mk(0, 4'h0, 0, 0, 3'd1, 5'b00000, 5'b00000, 0, 0);
        tbl[8]  = mk(0, 4'h0, 1, 0, 3'd1, 5'b00000, 5'b00000, 0, 1);
        tbl[9]  = mk(0, 4'h4, 0, 0, 3'd1, 5'b00000, 5'b00000, 0, 1);
        tbl[10] = mk(0, 4'h0, 0, 0, 3'd1, 5'b00000, 5'b00001, 0, 1);
        tbl[11] = mk(0, 4'h2, 0, 0, 3'd1, 5'b00000, 5'b00000, 0, 1);
        tbl[12] = mk(0, 4'h0, 0, 0, 3'd2, 5'b00000, 5'b00000, 0, 0);
        tbl[13] = mk(0, 4'hF, 0, 0, 3'd2, 5'b00000, 5'b00000, 0, 0);
        tbl[14] = mk(0, 4'h0, 0, 0, 3'd0, 5'b00000, 5'b00000, 0, 0);
        tbl[15] = mk(0, 4'h0, 1, 1, 3'd0, 5'b00000, 5'b00000, 1, 0);
        tbl[16] = mk(0, 4'h0, 0, 1, 3'd0, 5'b00000, 5'b00000, 0, 0);
        tbl[17] = mk(0, 4'h2, 0, 0, 3'd0, 5'b00000, 5'b00000, 0, 0);
        tbl[18] = mk(0, 4'h0, 1, 1, 3'd1, 5'b00000, 5'b00000, 1, 0);
        tbl[19] = mk(0, 4'h0, 1, 1, 3'd1, 5'b00000, 5'b00000, 0, 1);
        tbl[20] = mk(0, 4'h0, 1, 0, 3'd1, 5'b00000, 5'b00000, 0, 0);
        tbl[21] = mk(0, 4'h0, 1, 0, 3'd1, 5'b00000, 5'b00000, 0, 1);
        tbl[22] = mk(0, 4'h0, 0, 0, 3'd0, 5'b00000, 5'b00000, 0, 0);
        tbl[23] = mk(0, 4'h0, 0, 0, 3'd0, 5'b00000, 5'b00000, 0, 0);

        for (int i = 0; i < 24; i++) begin
            step(tbl[i].b, tbl[i].t, tbl[i].r, tbl[i].mid);
            cmp_out($sformatf("row%0d", i),
                    {tbl[i].mode, (tbl[i].mode == 3'd0), tbl[i].inc, tbl[i].dec, tbl[i].date, tbl[i].blink});
        end

        // Full NEXT cycle: one mode change per press, run_en low while editing.
        for (int i = 0; i < 6; i++) begin
            chg_cnt = 0;
            press(4'h2);
            chk($sformatf("cycle_mode%0d", i), int'(mode), (i + 1) % 6);
            chk($sformatf("cycle_run%0d", i), int'(run_en), (i == 5) ? 1 : 0);
            chk($sformatf("cycle_chg%0d", i), chg_cnt, 1);
        end

        // Edit strobes in SET_MIN.
        press(4'h2);
        press(4'h2);
        inc_min_cnt = 0; dec_min_cnt = 0; other_fld_cnt = 0;
        press(4'h1); press(4'h1); press(4'h1); press(4'h4);
        chk("inc_min_cnt", inc_min_cnt, 3);
        chk("dec_min_cnt", dec_min_cnt, 1);
        chk("other_fld", other_fld_cnt, 0);

        // Priority: INC+NEXT+EXIT together in SET_SEC exits without a strobe.
        press(4'h2);
        chk("prio_pre", int'(mode), 3);
        inc_min_cnt = 0; other_fld_cnt = 0;
        step(4'hB, 1'b0, 1'b0, 1'b0);
        step(4'h0, 1'b0, 1'b0, 1'b0);
        chk("prio_mode", int'(mode), 0);
        chk("prio_inc", other_fld_cnt + inc_min_cnt, 0);

        // Midnight in RUN fires once; in SET_HR it is suppressed.
        date_cnt = 0;
        step(4'h0, 1'b1, 1'b0, 1'b1);
        chk("mid_run", int'(date_inc), 1);
        step(4'h0, 1'b0, 1'b0, 1'b1);
        chk("mid_run_cnt", date_cnt, 1);
        press(4'h2);
        date_cnt = 0;
        step(4'h0, 1'b1, 1'b0, 1'b1);
        step(4'h0, 1'b0, 1'b0, 1'b1);
        chk("mid_set", date_cnt, 0);
        step(4'h8, 1'b0, 1'b0, 1'b0);
        step(4'h0, 1'b0, 1'b0, 1'b0);

        // Timeout out of SET_DAY after three idle ticks.
        for (int i = 0; i < 5; i++) press(4'h2);
        chk("to_pre", int'(mode), 5);
        for (int i = 0; i < 3; i++) begin
            step(4'h0, 1'b1, 1'b0, 1'b0);
            chk($sformatf("to_hold%0d", i), int'(mode), 5);
        end
        step(4'h0, 1'b0, 1'b0, 1'b0);
        chk("to_mode", int'(mode), 0);

        // Reset mid-edit in SET_MON.
        for (int i = 0; i < 4; i++) press(4'h2);
        step(4'h0, 1'b1, 1'b0, 1'b0);
        chk("rst_pre_blink", int'(blink), 1);
        step(4'h0, 1'b0, 1'b1, 1'b0);
        chk("rst_mode", int'(mode), 0);
        chk("rst_blink", int'(blink), 0);

        // Random stimulus against the model.
        rb = 4'd0;
        for (int i = 0; i < 3000; i++) begin
            for (int k = 0; k < 4; k++)
                if ($urandom_range(0, 7) == 0) rb[k] = ~rb[k];
            step(rb, ($urandom_range(0, 3) == 0), ($urandom_range(0, 299) == 0),
                 ($urandom_range(0, 3) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
